// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects, load-use and multi-cycle hazard detection,
// single-entry mul/div scoreboard and saturating stall counter.
module fwd_hazard_ctrl #(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_regw,
  input  logic                 id_mc,
  input  logic [NSRC*AW-1:0]   ex_rs,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_regw,
  input  logic                 ex_memread,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_regw,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_regw,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 bubble,
  output logic                 mc_issue,
  output logic                 sb_busy,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int CW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MC_LAT);

  logic [CW-1:0] sb_cnt;
  logic [AW-1:0] sb_rd;
  logic          m_ex;
  logic          m_sb;
  logic          load_use;
  logic          raw_mc;
  logic          waw_mc;
  logic          struct_mc;

  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      priority case (1'b1)
        mem_regw && (mem_rd != '0) &&
          (mem_rd == ex_rs[k*AW +: AW]):
          fwd_sel[2*k +: 2] = 2'b10;
        wb_regw && (wb_rd != '0) &&
          (wb_rd == ex_rs[k*AW +: AW]):
          fwd_sel[2*k +: 2] = 2'b01;
        default:
          fwd_sel[2*k +: 2] = 2'b00;
      endcase
    end
  end

  // x0 never matches, so an sb_rd of 0 only blocks via struct_mc
  always_comb begin
    m_ex = 1'b0;
    m_sb = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (id_rs_used[k] && (ex_rd != '0) &&
          (id_rs[k*AW +: AW] == ex_rd))
        m_ex = 1'b1;
      if (id_rs_used[k] && (sb_rd != '0) &&
          (id_rs[k*AW +: AW] == sb_rd))
        m_sb = 1'b1;
    end
  end

  assign sb_busy   = (sb_cnt != '0);
  assign load_use  = id_valid && ex_memread && ex_regw && m_ex;
  assign raw_mc    = id_valid && sb_busy && m_sb;
  assign waw_mc    = id_valid && sb_busy && id_regw &&
                     (id_rd == sb_rd) && (id_rd != '0);
  assign struct_mc = id_valid && sb_busy && id_mc;

  assign stall    = load_use | raw_mc | waw_mc | struct_mc;
  assign bubble   = stall;
  assign mc_issue = id_valid && id_mc && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_cnt <= '0;
      sb_rd  <= '0;
    end else if (mc_issue) begin
      sb_cnt <= LAT;
      sb_rd  <= id_regw ? id_rd : '0;
    end else if (sb_busy) begin
      sb_cnt <= sb_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: vector table, hand sequences and
// random stimulus against a cycle-numbered behavioural model.
module tb_fwd_hazard_ctrl;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int LAT  = 4;
  localparam int CW1  = 16;
  localparam int CW2  = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NSRC*AW-1:0] id_rs;
  logic [NSRC-1:0] id_rs_used;
  logic [AW-1:0] id_rd;
  logic id_regw, id_mc;
  logic [NSRC*AW-1:0] ex_rs;
  logic [AW-1:0] ex_rd;
  logic ex_regw, ex_memread;
  logic [AW-1:0] mem_rd, wb_rd;
  logic mem_regw, wb_regw;

  logic [2*NSRC-1:0] fwd_sel, fwd_sel_s;
  logic stall, bubble, mc_issue, sb_busy;
  logic stall_s, bubble_s, mc_issue_s, sb_busy_s;
  logic [CW1-1:0] stall_cnt;
  logic [CW2-1:0] stall_cnt_s;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .MC_LAT(LAT), .CNT_W(CW1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regw(id_regw),
    .id_mc(id_mc), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regw(ex_regw),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regw(mem_regw),
    .wb_rd(wb_rd), .wb_regw(wb_regw), .fwd_sel(fwd_sel),
    .stall(stall), .bubble(bubble), .mc_issue(mc_issue),
    .sb_busy(sb_busy), .stall_cnt(stall_cnt));

  fwd_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .MC_LAT(LAT), .CNT_W(CW2)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regw(id_regw),
    .id_mc(id_mc), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regw(ex_regw),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regw(mem_regw),
    .wb_rd(wb_rd), .wb_regw(wb_regw), .fwd_sel(fwd_sel_s),
    .stall(stall_s), .bubble(bubble_s), .mc_issue(mc_issue_s),
    .sb_busy(sb_busy_s), .stall_cnt(stall_cnt_s));

  int total = 0;
  int passed = 0;

  // model: edge count, busy while cyc < busy_until
  int cyc = 0;
  int busy_until = 0;
  logic [AW-1:0] m_rd = '0;
  int m_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [AW-1:0] src(logic [NSRC*AW-1:0] v, int k);
    return v[k*AW +: AW];
  endfunction

  function automatic bit id_reads(logic [AW-1:0] r);
    if (r == 0) return 0;
    for (int k = 0; k < NSRC; k++)
      if (id_rs_used[k] && src(id_rs, k) == r) return 1;
    return 0;
  endfunction

  function automatic logic [2*NSRC-1:0] m_fwd();
    logic [2*NSRC-1:0] f;
    f = '0;
    for (int k = 0; k < NSRC; k++) begin
      logic [AW-1:0] a;
      a = src(ex_rs, k);
      if (a != 0 && mem_regw && mem_rd == a) f[2*k +: 2] = 2'b10;
      else if (a != 0 && wb_regw && wb_rd == a) f[2*k +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic bit m_busy();
    return cyc < busy_until;
  endfunction

  function automatic bit m_stall();
    bit h;
    h = (ex_memread && ex_regw && id_reads(ex_rd));
    if (m_busy()) begin
      h |= id_reads(m_rd);
      h |= id_regw && id_rd == m_rd && id_rd != 0;
      h |= id_mc;
    end
    return id_valid && h;
  endfunction

  function automatic int sat(int v, int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic settle(string nm);
    bit s;
    #4;
    s = m_stall();
    chk({nm, ".fwd"}, 32'(fwd_sel), 32'(m_fwd()));
    chk({nm, ".stall"}, 32'(stall), 32'(s));
    chk({nm, ".bubble"}, 32'(bubble), 32'(s));
    chk({nm, ".issue"}, 32'(mc_issue), 32'(id_valid && id_mc && !s));
    chk({nm, ".busy"}, 32'(sb_busy), 32'(m_busy()));
    chk({nm, ".cnt"}, 32'(stall_cnt), 32'(sat(m_cnt, CW1)));
    chk({nm, ".cnt3"}, 32'(stall_cnt_s), 32'(sat(m_cnt, CW2)));
  endtask

  task automatic adv();
    bit s, iss;
    @(posedge clk);
    s = m_stall();
    iss = id_valid && id_mc && !s;
    cyc++;
    if (rst) begin
      busy_until = cyc;
      m_rd = '0;
      m_cnt = 0;
    end else begin
      if (iss) begin
        busy_until = cyc + LAT;
        m_rd = id_regw ? id_rd : '0;
      end
      if (s) m_cnt++;
    end
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_regw = 0; id_mc = 0; ex_rs = '0; ex_rd = '0;
    ex_regw = 0; ex_memread = 0; mem_rd = '0; mem_regw = 0;
    wb_rd = '0; wb_regw = 0;
  endtask

  typedef struct {
    logic [AW-1:0] ers0, ers1, mrd;
    logic mw;
    logic [AW-1:0] wrd;
    logic ww;
    logic [AW-1:0] irs1;
    logic used1, memrd;
    logic [AW-1:0] exrd;
    logic [3:0] efwd;
    logic estall;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n, c0;
    bit got;
    vt[0] = '{5'd5, 5'd0, 5'd5, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 4'b0010, 0};
    vt[1] = '{5'd5, 5'd0, 5'd5, 0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 4'b0001, 0};
    vt[2] = '{5'd0, 5'd0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 4'b0000, 0};
    vt[3] = '{5'd3, 5'd6, 5'd6, 1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 4'b1001, 0};
    vt[4] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 5'd7, 4'b0000, 1};
    vt[5] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd7, 0, 1, 5'd7, 4'b0000, 0};
    vt[6] = '{5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 5'd0, 4'b0000, 0};
    vt[7] = '{5'd0, 5'd5, 5'd4, 1, 5'd5, 0, 5'd0, 0, 0, 5'd0, 4'b0000, 0};

    clr();
    rst = 1;
    adv();
    adv();
    rst = 0;
    settle("reset");
    chk("reset_busy", 32'(sb_busy), 0);
    chk("reset_cnt", 32'(stall_cnt), 0);
    adv();

    for (int i = 0; i < 8; i++) begin
      clr();
      id_valid = 1; ex_regw = 1;
      ex_rs = {vt[i].ers1, vt[i].ers0};
      mem_rd = vt[i].mrd; mem_regw = vt[i].mw;
      wb_rd = vt[i].wrd; wb_regw = vt[i].ww;
      id_rs = {vt[i].irs1, 5'd0};
      id_rs_used = {vt[i].used1, 1'b0};
      ex_memread = vt[i].memrd; ex_rd = vt[i].exrd;
      c0 = m_cnt;
      settle("vec");
      chk($sformatf("vec%0d_fwd", i), 32'(fwd_sel), 32'(vt[i].efwd));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].estall));
      adv();
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(c0 + int'(vt[i].estall)));
    end

    // multi-cycle RAW on x9
    clr();
    id_valid = 1; id_mc = 1; id_regw = 1; id_rd = 9;
    settle("raw_iss");
    chk("raw_issue", 32'(mc_issue), 1);
    adv();
    id_mc = 0; id_rd = 10; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
    c0 = m_cnt;
    for (int i = 0; i < 5; i++) begin
      settle("raw");
      chk($sformatf("raw_stall%0d", i), 32'(stall), 32'(i < 4));
      adv();
    end
    chk("raw_cnt", 32'(stall_cnt), 32'(c0 + 4));

    // back-to-back mc ops, then WAW and independent ALU op
    clr();
    id_valid = 1; id_mc = 1; id_regw = 1; id_rd = 3;
    settle("st_iss");
    chk("st_issue1", 32'(mc_issue), 1);
    adv();
    n = 0; got = 0;
    while (!got && n < 20) begin
      n++;
      settle("st_wait");
      if (mc_issue === 1'b1) got = 1;
      adv();
    end
    chk("mc_spacing", 32'(n), 5);
    id_mc = 0; id_rd = 3;
    settle("waw");
    chk("waw_stall", 32'(stall), 1);
    adv();
    id_rd = 4;
    settle("nowaw");
    chk("nowaw_stall", 32'(stall), 0);
    adv();

    // reset during outstanding op
    clr();
    for (int i = 0; i < 6; i++) begin settle("drain"); adv(); end
    id_valid = 1; id_mc = 1; id_regw = 1; id_rd = 9;
    settle("rs_iss"); adv();
    clr();
    settle("rs_c1"); adv();
    rst = 1;
    settle("rs_c2"); adv();
    rst = 0;
    id_valid = 1; id_rs = {5'd9, 5'd9}; id_rs_used = 2'b11;
    settle("rs_after");
    chk("rs_busy", 32'(sb_busy), 0);
    chk("rs_cnt", 32'(stall_cnt), 0);
    chk("rs_stall", 32'(stall), 0);
    adv();

    // saturation of the 3-bit counter
    clr();
    id_valid = 1; ex_memread = 1; ex_regw = 1; ex_rd = 7;
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    for (int i = 0; i < 10; i++) begin settle("sat"); adv(); end
    settle("sat_end");
    chk("sat_cnt3", 32'(stall_cnt_s), 7);
    chk("sat_cnt16", 32'(stall_cnt), 10);
    adv();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used = 2'($urandom);
      id_rd = 5'($urandom_range(0, 7));
      id_regw = 1'($urandom);
      id_mc = ($urandom_range(0, 3) == 0);
      ex_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rd = 5'($urandom_range(0, 7));
      ex_regw = 1'($urandom);
      ex_memread = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 7));
      mem_regw = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 7));
      wb_regw = 1'($urandom);
      settle("rand");
      adv();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
